// File: rtl/conv_layer_sequencer.sv
// rtl/conv_layer_sequencer.sv - command sequencer for the conv layer input interface and kernel array
//
// Issues PRELOAD/SHIFT/LOAD commands to the conv input interface. Each image takes
// NUM_FEATURE kernels x NUM_ROW rows. A run covers NUM_IMAGE images, or repeats images
// until stop when continuous=1. Every accepted SHIFT_FIN is tagged with its
// {feature, row} and carried through a FIN_LATENCY-deep pipe, so the tag lines up with
// the kernel result.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   enable               0 freezes the FSM and forces cmd to IDLE
//   start, continuous    begin a run (sampled in IDLE); repeat images until stop
//   stop                 finish the current image, then end the run
//   input_interface_ack  0 none, 1 PRELOAD_FIN, 2 SHIFT_FIN, 3 LOAD_FIN (one-cycle pulse)
//   input_interface_cmd  0 IDLE, 1 PRELOAD, 2 SHIFT, 3 LOAD (one-cycle pulse)
//   kernel_array_clear   pulse the cycle after each accepted SHIFT_FIN
//   kernel_calc_fin      kernel result valid, FIN_LATENCY cycles after its SHIFT_FIN
//   feature_idx/row      tag of the result; holds while kernel_calc_fin=0
//   image_calc_fin       with the last kernel_calc_fin of an image
//   busy, done, err      run in progress; end-of-run pulse; sticky protocol error

module conv_layer_sequencer #(
    parameter int NUM_FEATURE = 3,
    parameter int NUM_ROW     = 6,
    parameter int NUM_IMAGE   = 1,
    parameter int FIN_LATENCY = 3,
    parameter int IDX_W       = (NUM_FEATURE > 1) ? $clog2(NUM_FEATURE) : 1,
    parameter int ROW_W       = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1,
    parameter int IMG_W       = (NUM_IMAGE > 1) ? $clog2(NUM_IMAGE) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             start,
    input  logic             continuous,
    input  logic             stop,
    input  logic [1:0]       input_interface_ack,
    output logic [1:0]       input_interface_cmd,
    output logic             kernel_array_clear,
    output logic             kernel_calc_fin,
    output logic [IDX_W-1:0] feature_idx,
    output logic [ROW_W-1:0] feature_row,
    output logic             image_calc_fin,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] CMD_IDLE        = 2'd0;
    localparam logic [1:0] CMD_PRELOAD     = 2'd1;
    localparam logic [1:0] CMD_SHIFT       = 2'd2;
    localparam logic [1:0] CMD_LOAD        = 2'd3;
    localparam logic [1:0] ACK_NONE        = 2'd0;
    localparam logic [1:0] ACK_PRELOAD_FIN = 2'd1;
    localparam logic [1:0] ACK_SHIFT_FIN   = 2'd2;
    localparam logic [1:0] ACK_LOAD_FIN    = 2'd3;

    localparam logic [IDX_W-1:0] W_LAST   = IDX_W'(NUM_FEATURE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROW - 1);
    localparam logic [IMG_W-1:0] IMG_LAST = IMG_W'(NUM_IMAGE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRELOAD,
        S_SHIFT,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] w;
    logic [ROW_W-1:0] row;
    logic [IMG_W-1:0] img;
    logic             stop_seen;
    logic             pend_valid;
    logic [1:0]       pend_ack;

    // Fin pipe. Tag fields only advance alongside a valid entry, so the output stage
    // keeps the last delivered tag between results without an extra hold register.
    logic [FIN_LATENCY-1:0] pipe_valid;
    logic [FIN_LATENCY-1:0] pipe_last;
    logic [IDX_W-1:0]       pipe_idx [FIN_LATENCY];
    logic [ROW_W-1:0]       pipe_row [FIN_LATENCY];

    logic [1:0] eff_ack;
    logic [1:0] exp_ack;
    logic       ack_bad;
    logic       shift_accept;
    logic       w_last;
    logic       row_last;
    logic       more_images;
    logic       pipe_empty;

    // While stalled the ack is parked in pend_ack. On the first enabled cycle the parked
    // ack takes priority over the live input.
    always_comb begin
        eff_ack = ACK_NONE;
        if (enable) begin
            eff_ack = pend_valid ? pend_ack : input_interface_ack;
        end
    end

    always_comb begin
        exp_ack = ACK_NONE;
        case (state)
            S_PRELOAD: exp_ack = ACK_PRELOAD_FIN;
            S_SHIFT:   exp_ack = ACK_SHIFT_FIN;
            S_LOAD:    exp_ack = ACK_LOAD_FIN;
            default:   exp_ack = ACK_NONE;
        endcase
    end

    assign ack_bad      = (eff_ack != ACK_NONE) && (eff_ack != exp_ack);
    assign shift_accept = (state == S_SHIFT) && (eff_ack == ACK_SHIFT_FIN);
    assign w_last       = (w == W_LAST);
    assign row_last     = (row == ROW_LAST);
    // A stop in the same cycle as the final SHIFT_FIN still ends the run.
    assign more_images  = continuous ? !(stop_seen || stop) : (img != IMG_LAST);
    assign pipe_empty   = (pipe_valid == '0);

    assign kernel_calc_fin = pipe_valid[FIN_LATENCY-1];
    assign feature_idx     = pipe_idx[FIN_LATENCY-1];
    assign feature_row     = pipe_row[FIN_LATENCY-1];
    assign image_calc_fin  = pipe_last[FIN_LATENCY-1];

    // The fin pipe keeps shifting during a stall, so results already in flight still land
    // on time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            pipe_last  <= '0;
            for (int i = 0; i < FIN_LATENCY; i++) begin
                pipe_idx[i] <= '0;
                pipe_row[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= shift_accept;
            pipe_last[0]  <= shift_accept & w_last & row_last;
            if (shift_accept) begin
                pipe_idx[0] <= w;
                pipe_row[0] <= row;
            end
            for (int i = 1; i < FIN_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_last[i]  <= pipe_last[i-1];
                if (pipe_valid[i-1]) begin
                    pipe_idx[i] <= pipe_idx[i-1];
                    pipe_row[i] <= pipe_row[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= S_IDLE;
            w                   <= '0;
            row                 <= '0;
            img                 <= '0;
            stop_seen           <= 1'b0;
            pend_valid          <= 1'b0;
            pend_ack            <= ACK_NONE;
            input_interface_cmd <= CMD_IDLE;
            kernel_array_clear  <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
            err                 <= 1'b0;
        end else begin
            input_interface_cmd <= CMD_IDLE;
            kernel_array_clear  <= shift_accept;
            done                <= 1'b0;

            if (busy && stop) begin
                stop_seen <= 1'b1;
            end

            if (!enable) begin
                if (input_interface_ack != ACK_NONE) begin
                    if (pend_valid) begin
                        err <= 1'b1;
                    end else begin
                        pend_ack   <= input_interface_ack;
                        pend_valid <= 1'b1;
                    end
                end
            end else begin
                pend_valid <= 1'b0;
                // A fresh ack on the cycle a parked ack is consumed is a second ack.
                if (pend_valid && (input_interface_ack != ACK_NONE)) begin
                    err <= 1'b1;
                end
                if (ack_bad) begin
                    err <= 1'b1;
                end

                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state               <= S_PRELOAD;
                            input_interface_cmd <= CMD_PRELOAD;
                            busy                <= 1'b1;
                            w                   <= '0;
                            row                 <= '0;
                            img                 <= '0;
                        end
                    end
                    S_PRELOAD: begin
                        if (eff_ack == ACK_PRELOAD_FIN) begin
                            state               <= S_SHIFT;
                            input_interface_cmd <= CMD_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        if (shift_accept) begin
                            if (!w_last) begin
                                w                   <= w + 1'b1;
                                input_interface_cmd <= CMD_SHIFT;
                            end else if (!row_last) begin
                                w                   <= '0;
                                row                 <= row + 1'b1;
                                state               <= S_LOAD;
                                input_interface_cmd <= CMD_LOAD;
                            end else begin
                                w   <= '0;
                                row <= '0;
                                if (more_images) begin
                                    img                 <= (img == IMG_LAST) ? '0 : img + 1'b1;
                                    state               <= S_PRELOAD;
                                    input_interface_cmd <= CMD_PRELOAD;
                                end else begin
                                    state <= S_DRAIN;
                                end
                            end
                        end
                    end
                    S_LOAD: begin
                        if (eff_ack == ACK_LOAD_FIN) begin
                            state               <= S_SHIFT;
                            input_interface_cmd <= CMD_SHIFT;
                        end
                    end
                    S_DRAIN: begin
                        if (pipe_empty) begin
                            state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        stop_seen <= 1'b0;
                        state     <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// tb/tb_conv_layer_sequencer.sv - scoreboard bench for conv_layer_sequencer

module tb_conv_layer_sequencer;

    localparam int NF = 3;
    localparam int NR = 6;
    localparam int LAT = 3;

    logic       clk = 1'b0;
    logic       rst, enable, start, continuous, stop;
    logic [1:0] ack;
    logic       sel;

    logic [1:0] a_cmd, b_cmd, m_cmd;
    logic       a_clr, b_clr, m_clr;
    logic       a_fin, b_fin, m_fin;
    logic [1:0] a_idx, b_idx, m_idx;
    logic [2:0] a_row, b_row, m_row;
    logic       a_img, b_img, m_img;
    logic       a_busy, b_busy, m_busy;
    logic       a_done, b_done, m_done;
    logic       a_err, b_err, m_err;

    conv_layer_sequencer #(.NUM_FEATURE(NF), .NUM_ROW(NR), .NUM_IMAGE(1), .FIN_LATENCY(LAT)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .start(start & ~sel), .continuous(continuous),
        .stop(stop), .input_interface_ack(sel ? 2'd0 : ack), .input_interface_cmd(a_cmd),
        .kernel_array_clear(a_clr), .kernel_calc_fin(a_fin), .feature_idx(a_idx),
        .feature_row(a_row), .image_calc_fin(a_img), .busy(a_busy), .done(a_done), .err(a_err)
    );

    conv_layer_sequencer #(.NUM_FEATURE(NF), .NUM_ROW(NR), .NUM_IMAGE(2), .FIN_LATENCY(LAT)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .start(start & sel), .continuous(continuous),
        .stop(stop), .input_interface_ack(sel ? ack : 2'd0), .input_interface_cmd(b_cmd),
        .kernel_array_clear(b_clr), .kernel_calc_fin(b_fin), .feature_idx(b_idx),
        .feature_row(b_row), .image_calc_fin(b_img), .busy(b_busy), .done(b_done), .err(b_err)
    );

    always_comb begin
        if (sel) begin
            m_cmd = b_cmd; m_clr = b_clr; m_fin = b_fin; m_idx = b_idx; m_row = b_row;
            m_img = b_img; m_busy = b_busy; m_done = b_done; m_err = b_err;
        end else begin
            m_cmd = a_cmd; m_clr = a_clr; m_fin = a_fin; m_idx = a_idx; m_row = a_row;
            m_img = a_img; m_busy = a_busy; m_done = a_done; m_err = a_err;
        end
    end

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    function automatic void check(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct {
        int cyc;
        int idx;
        int row;
        bit last;
    } fin_t;

    fin_t tags[$];      // reference order of results for the current run
    fin_t exp_fin[$];   // scoreboard: timed expected results
    int   exp_clr[$];   // scoreboard: expected clear cycles

    // Interface model: answers every command after a random delay.
    typedef struct {
        int         due;
        logic [1:0] val;
    } ack_ev_t;

    ack_ev_t    rq[$];
    int         resp_min = 2;
    int         resp_max = 2;
    logic [1:0] inject = 2'd0;

    initial begin
        ack_ev_t ev;
        ack = 2'd0;
        forever begin
            @(posedge clk);
            #1;
            ack = 2'd0;
            if (rst) begin
                rq.delete();
                inject = 2'd0;
            end else begin
                if (m_cmd != 2'd0) begin
                    ev.due = cyc + int'($urandom_range(resp_max, resp_min));
                    ev.val = m_cmd;
                    rq.push_back(ev);
                end
                if (rq.size() > 0 && rq[0].due == cyc) begin
                    ev  = rq.pop_front();
                    ack = ev.val;
                end else if (inject != 2'd0) begin
                    ack    = inject;
                    inject = 2'd0;
                end
            end
        end
    end

    // Monitor: models ack acceptance (including the stall parking slot) to time each
    // expected result, then compares whatever the DUT presents this cycle.
    int n_pre = 0, n_shift = 0, n_load = 0, n_fin = 0, n_img = 0, n_done = 0;
    int last_img_cyc = 0, last_done_cyc = 0;

    initial begin
        bit         pend_v;
        logic [1:0] pend;
        logic [1:0] a;
        fin_t       t;
        int         hold_idx, hold_row;
        pend_v = 1'b0; pend = 2'd0; hold_idx = 0; hold_row = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_v = 1'b0;
                exp_fin.delete();
                exp_clr.delete();
                hold_idx = 0;
                hold_row = 0;
            end else begin
                a = 2'd0;
                if (enable) begin
                    a = pend_v ? pend : ack;
                    pend_v = 1'b0;
                end else if (ack != 2'd0 && !pend_v) begin
                    pend   = ack;
                    pend_v = 1'b1;
                end
                if (a == 2'd2) begin
                    if (tags.size() == 0) begin
                        check("extra_shift_fin", 1, 0);
                    end else begin
                        t = tags.pop_front();
                        t.cyc = cyc + LAT;
                        exp_fin.push_back(t);
                        exp_clr.push_back(cyc + 1);
                    end
                end

                if (m_clr) begin
                    if (exp_clr.size() == 0) check("clear_unexpected", 1, 0);
                    else check("clear_cycle", cyc, exp_clr.pop_front());
                end
                if (m_fin) begin
                    n_fin++;
                    if (exp_fin.size() == 0) begin
                        check("fin_unexpected", 1, 0);
                    end else begin
                        t = exp_fin.pop_front();
                        check("fin_cycle", cyc, t.cyc);
                        check("fin_idx", m_idx, t.idx);
                        check("fin_row", m_row, t.row);
                        check("image_fin_flag", m_img, t.last);
                        hold_idx = t.idx;
                        hold_row = t.row;
                    end
                end else begin
                    check("idx_hold", m_idx, hold_idx);
                    check("row_hold", m_row, hold_row);
                    if (m_img) check("image_fin_without_fin", 1, 0);
                end
                if (m_cmd == 2'd1) n_pre++;
                if (m_cmd == 2'd2) n_shift++;
                if (m_cmd == 2'd3) n_load++;
                if (m_img) begin n_img++; last_img_cyc = cyc; end
                if (m_done) begin n_done++; last_done_cyc = cyc; end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int s_pre, s_shift, s_load, s_fin, s_img, s_done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s_pre = n_pre; s_shift = n_shift; s_load = n_load;
        s_fin = n_fin; s_img = n_img; s_done = n_done;
    endtask

    task automatic load_tags(int images);
        fin_t t;
        for (int i = 0; i < images; i++)
            for (int r = 0; r < NR; r++)
                for (int f = 0; f < NF; f++) begin
                    t.cyc = 0; t.idx = f; t.row = r; t.last = (f == NF - 1) && (r == NR - 1);
                    tags.push_back(t);
                end
    endtask

    task automatic check_outputs_zero(string nm);
        check({nm, "_cmd"}, m_cmd, 0);
        check({nm, "_clear"}, m_clr, 0);
        check({nm, "_calc_fin"}, m_fin, 0);
        check({nm, "_idx"}, m_idx, 0);
        check({nm, "_row"}, m_row, 0);
        check({nm, "_image_fin"}, m_img, 0);
        check({nm, "_busy"}, m_busy, 0);
        check({nm, "_done"}, m_done, 0);
        check({nm, "_err"}, m_err, 0);
    endtask

    task automatic do_reset(logic new_sel);
        rst = 1'b1;
        sel = new_sel;
        tick();
        tick();
        tags.delete();
        rst = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        snap();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(string nm, int budget);
        int k = 0;
        while (n_done == s_done && k < budget) begin
            tick();
            k++;
        end
        if (n_done == s_done) check({nm, "_done_timeout"}, 0, 1);
        repeat (6) tick();
    endtask

    task automatic wait_shift_cmds(string nm, int k);
        int seen = 0;
        int g = 0;
        while (seen < k && g < 1000) begin
            tick();
            g++;
            if (m_cmd == 2'd2) seen++;
        end
        if (seen < k) check({nm, "_shift_wait_timeout"}, seen, k);
    endtask

    task automatic check_run(string nm, int pre, int sh, int ld, int imgs, int e);
        check({nm, "_preload_cmds"}, n_pre - s_pre, pre);
        check({nm, "_shift_cmds"}, n_shift - s_shift, sh);
        check({nm, "_load_cmds"}, n_load - s_load, ld);
        check({nm, "_calc_fins"}, n_fin - s_fin, sh);
        check({nm, "_image_fins"}, n_img - s_img, imgs);
        check({nm, "_done_pulses"}, n_done - s_done, 1);
        check({nm, "_busy_after"}, m_busy, 0);
        check({nm, "_err"}, m_err, e);
        check({nm, "_results_outstanding"}, exp_fin.size(), 0);
        check({nm, "_tags_left"}, tags.size(), 0);
        check({nm, "_done_after_last_image"},
              (n_done > s_done && last_done_cyc > last_img_cyc) ? 1 : 0, 1);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; start = 1'b0; continuous = 1'b0; stop = 1'b0; sel = 1'b0;
        repeat (3) tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        enable = 1'b1;
        tick();

        // Default run, interface answers 2 cycles after each command.
        resp_min = 2; resp_max = 2;
        load_tags(1);
        pulse_start();
        wait_done("single", 2000);
        check_run("single", 1, NF * NR, NR - 1, 1, 0);

        // Stall for 5 cycles while a SHIFT_FIN is in flight.
        do_reset(1'b0);
        resp_min = 2; resp_max = 4;
        load_tags(1);
        pulse_start();
        wait_shift_cmds("stall", int'($urandom_range(12, 2)));
        tick();
        enable = 1'b0;
        repeat (5) tick();
        enable = 1'b1;
        wait_done("stall", 2000);
        check_run("stall", 1, NF * NR, NR - 1, 1, 0);

        // Stray LOAD_FIN while waiting for SHIFT_FIN.
        do_reset(1'b0);
        resp_min = 3; resp_max = 3;
        load_tags(1);
        pulse_start();
        wait_shift_cmds("stray", int'($urandom_range(15, 1)));
        inject = 2'd3;
        wait_done("stray", 2000);
        check_run("stray", 1, NF * NR, NR - 1, 1, 1);
        do_reset(1'b0);
        check("err_cleared_by_reset", m_err, 0);

        // Two images per start.
        do_reset(1'b1);
        resp_min = 1; resp_max = 4;
        load_tags(2);
        pulse_start();
        wait_done("two_image", 4000);
        check_run("two_image", 2, 2 * NF * NR, 2 * (NR - 1), 2, 0);

        // Continuous mode, stop during the second image.
        do_reset(1'b0);
        continuous = 1'b1;
        load_tags(2);
        pulse_start();
        begin
            int g = 0;
            while (n_pre - s_pre < 2 && g < 2000) begin tick(); g++; end
            if (n_pre - s_pre < 2) check("continuous_second_image_timeout", n_pre - s_pre, 2);
        end
        wait_shift_cmds("continuous", int'($urandom_range(8, 1)));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done("continuous", 4000);
        check_run("continuous", 2, 2 * NF * NR, 2 * (NR - 1), 2, 0);
        continuous = 1'b0;

        // Reset in the middle of SHIFT, then replay from the start.
        do_reset(1'b0);
        resp_min = 2; resp_max = 2;
        load_tags(1);
        pulse_start();
        wait_shift_cmds("midreset", int'($urandom_range(12, 3)));
        tick();
        rst = 1'b1;
        #1;
        check_outputs_zero("midreset");
        tick();
        tags.delete();
        rst = 1'b0;
        tick();
        load_tags(1);
        pulse_start();
        wait_done("replay", 2000);
        check_run("replay", 1, NF * NR, NR - 1, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
